spi_master_cs_ctrl: RTL and testbench

SPI_MASTER_CS_CTRL -- requirements
Module: spi_master_cs_ctrl

---
 rtl/spi_master_cs_ctrl.sv | 176 +++++++++++++++++
 tb/tb_spi_master_cs_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cs_ctrl.sv
// Chip-select window controller between an upstream byte source and an SPI byte engine.
// Define SPI_CS_LEAD_DELAY_EN to hold CS low for CS_LEAD_CLKS cycles before the first byte.
module spi_master_cs_ctrl #(
  parameter int unsigned SPI_MODE          = 0,
  parameter int unsigned CLKS_PER_HALF_BIT = 8,
  parameter int unsigned MAX_BYTES_PER_CS  = 2,
  parameter int unsigned CS_INACTIVE_CLKS  = 1,
  parameter int unsigned CS_LEAD_CLKS      = 4,
  localparam int unsigned CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic [CW-1:0] o_RX_Count,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic [7:0]    o_M_TX_Byte,
  output logic          o_M_TX_DV,
  input  logic          i_M_TX_Ready,
  input  logic          i_M_RX_DV,
  input  logic [7:0]    i_M_RX_Byte,
  output logic          o_SPI_CS_n
);

  localparam logic [CW-1:0] MaxCount = CW'(MAX_BYTES_PER_CS);
  localparam int unsigned   IW       = (CS_INACTIVE_CLKS < 2) ? 1 : $clog2(CS_INACTIVE_CLKS);
  localparam logic [IW-1:0] InactLast =
    (CS_INACTIVE_CLKS == 0) ? '0 : IW'(CS_INACTIVE_CLKS - 1);

`ifdef SPI_CS_LEAD_DELAY_EN
  localparam int unsigned   LW       = (CS_LEAD_CLKS < 2) ? 1 : $clog2(CS_LEAD_CLKS);
  localparam logic [LW-1:0] LeadLast = (CS_LEAD_CLKS == 0) ? '0 : LW'(CS_LEAD_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StCsLead, StTransfer, StCsInactive} state_e;
`else
  typedef enum logic [1:0] {StIdle, StTransfer, StCsInactive} state_e;
`endif

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_remaining;
  logic [IW-1:0] r_inact_cnt;
  logic [CW-1:0] r_rx_idx;
  logic [CW-1:0] r_rx_count;
  logic          r_m_tx_dv, r_cs_n, r_rx_dv;
  logic [7:0]    r_m_tx_byte, r_rx_byte;
`ifdef SPI_CS_LEAD_DELAY_EN
  logic [LW-1:0] r_lead_cnt;
  logic          w_lead_done;
`endif

  logic w_tx_ready, w_count_ok, w_first, w_more, w_release;
  logic w_unused_params;

  // Engine timing parameters only matter to the attached byte engine.
  assign w_unused_params = (SPI_MODE > 3) ^ (CLKS_PER_HALF_BIT == 0) ^ (CS_LEAD_CLKS == 0);

  assign w_count_ok = (i_TX_Count != '0) && (i_TX_Count <= MaxCount);

  always_comb begin
    w_state_next = r_state;
    w_tx_ready   = 1'b0;
    w_first      = 1'b0;
    w_more       = 1'b0;
    w_release    = 1'b0;
`ifdef SPI_CS_LEAD_DELAY_EN
    w_lead_done  = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        w_tx_ready = i_M_TX_Ready;
        if (i_TX_DV && i_M_TX_Ready && w_count_ok) begin
          w_first = 1'b1;
`ifdef SPI_CS_LEAD_DELAY_EN
          w_state_next = StCsLead;
`else
          w_state_next = StTransfer;
`endif
        end
      end
`ifdef SPI_CS_LEAD_DELAY_EN
      StCsLead: begin
        if (r_lead_cnt == LeadLast) begin
          w_lead_done  = 1'b1;
          w_state_next = StTransfer;
        end
      end
`endif
      StTransfer: begin
        // Engine ready is stale during the forward cycle, so it is masked there.
        w_tx_ready = i_M_TX_Ready && (r_remaining != '0) && !r_m_tx_dv;
        w_more     = i_TX_DV && w_tx_ready;
        if (i_M_TX_Ready && (r_remaining == '0) && !r_m_tx_dv) begin
          w_release    = 1'b1;
          w_state_next = StCsInactive;
        end
      end
      StCsInactive: begin
        if (r_inact_cnt == InactLast) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    if (i_Rst) w_tx_ready = 1'b0;
  end

  assign o_TX_Ready = w_tx_ready;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_remaining <= '0;
      r_inact_cnt <= '0;
      r_rx_idx    <= '0;
      r_rx_count  <= '0;
      r_m_tx_dv   <= 1'b0;
      r_m_tx_byte <= '0;
      r_cs_n      <= 1'b1;
      r_rx_dv     <= 1'b0;
      r_rx_byte   <= '0;
`ifdef SPI_CS_LEAD_DELAY_EN
      r_lead_cnt  <= '0;
`endif
    end else begin
      r_m_tx_dv <= 1'b0;
      if (w_first) begin
        r_remaining <= i_TX_Count - CW'(1);
        r_m_tx_byte <= i_TX_Byte;
        r_cs_n      <= 1'b0;
`ifdef SPI_CS_LEAD_DELAY_EN
        r_lead_cnt  <= '0;
`else
        r_m_tx_dv   <= 1'b1;
`endif
      end
`ifdef SPI_CS_LEAD_DELAY_EN
      if (w_lead_done)             r_m_tx_dv  <= 1'b1;
      else if (r_state == StCsLead) r_lead_cnt <= r_lead_cnt + LW'(1);
`endif
      if (w_more) begin
        r_remaining <= r_remaining - CW'(1);
        r_m_tx_byte <= i_TX_Byte;
        r_m_tx_dv   <= 1'b1;
      end
      if (w_release) begin
        r_cs_n      <= 1'b1;
        r_inact_cnt <= '0;
      end else if (r_state == StCsInactive) begin
        r_inact_cnt <= r_inact_cnt + IW'(1);
      end

      // A late byte still takes its index before the counter clears on CS high.
      r_rx_dv <= i_M_RX_DV;
      if (i_M_RX_DV) begin
        r_rx_byte  <= i_M_RX_Byte;
        r_rx_count <= r_rx_idx;
        if (r_rx_idx != MaxCount) r_rx_idx <= r_rx_idx + CW'(1);
      end else if (r_cs_n) begin
        r_rx_idx <= '0;
      end
    end
  end

  assign o_M_TX_DV   = r_m_tx_dv;
  assign o_M_TX_Byte = r_m_tx_byte;
  assign o_SPI_CS_n  = r_cs_n;
  assign o_RX_DV     = r_rx_dv;
  assign o_RX_Byte   = r_rx_byte;
  assign o_RX_Count  = r_rx_count;

endmodule

// File: tb/tb_spi_master_cs_ctrl.sv
// Bench for spi_master_cs_ctrl: loopback byte-engine model plus queue-based window scoreboard.
module tb_spi_master_cs_ctrl;

  localparam int MaxBytes  = 2;
  localparam int InactClks = 1;
  localparam int LeadClks  = 4;
  localparam int CW        = $clog2(MaxBytes + 1);
`ifdef SPI_CS_LEAD_DELAY_EN
  localparam int LeadExp = LeadClks;
`else
  localparam int LeadExp = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] tx_count;
  logic [7:0]    tx_byte;
  logic          tx_dv;
  logic          tx_ready;
  logic [CW-1:0] rx_count;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic [7:0]    m_tx_byte;
  logic          m_tx_dv;
  logic          m_tx_ready;
  logic          m_rx_dv;
  logic [7:0]    m_rx_byte;
  logic          cs_n;

  spi_master_cs_ctrl #(
    .SPI_MODE         (0),
    .CLKS_PER_HALF_BIT(8),
    .MAX_BYTES_PER_CS (MaxBytes),
    .CS_INACTIVE_CLKS (InactClks),
    .CS_LEAD_CLKS     (LeadClks)
  ) u_dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_TX_Count  (tx_count),
    .i_TX_Byte   (tx_byte),
    .i_TX_DV     (tx_dv),
    .o_TX_Ready  (tx_ready),
    .o_RX_Count  (rx_count),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte),
    .o_M_TX_Byte (m_tx_byte),
    .o_M_TX_DV   (m_tx_dv),
    .i_M_TX_Ready(m_tx_ready),
    .i_M_RX_DV   (m_rx_dv),
    .i_M_RX_Byte (m_rx_byte),
    .o_SPI_CS_n  (cs_n)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         prev_cs = 1'b1;
  int         cs_falls = 0;
  int         exp_windows = 0;
  logic [7:0] exp_fwd[$];
  logic [7:0] exp_rx_byte[$];
  int         exp_rx_idx[$];
  bit         saw_fwd = 1'b0;
  bit         first_pending = 1'b0;
  int         acc_cyc = 0;
  int         eng_cnt = 0;
  logic [7:0] eng_byte = '0;
  int         eng_lo = 3;
  int         eng_hi = 8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (prev_cs && !cs_n) cs_falls++;
    prev_cs = cs_n;
    if (m_tx_dv) begin
      chk("fwd_cs_low", cs_n, 0);
      chk("fwd_expected", exp_fwd.size() != 0, 1);
      if (exp_fwd.size() != 0) chk("fwd_byte", m_tx_byte, exp_fwd.pop_front());
      if (first_pending) begin
        chk("first_fwd_latency", cyc - acc_cyc, 1 + LeadExp);
        first_pending = 1'b0;
      end
      saw_fwd = 1'b1;
    end
    if (rx_dv) begin
      chk("rx_expected", exp_rx_idx.size() != 0, 1);
      if (exp_rx_idx.size() != 0) begin
        chk("rx_byte", rx_byte, exp_rx_byte.pop_front());
        chk("rx_index", rx_count, exp_rx_idx.pop_front());
      end
    end
  endtask

  // Loopback byte engine: ready drops the cycle after a start, returns with the echoed byte.
  task automatic engine();
    m_rx_dv = 1'b0;
    if (m_tx_dv) begin
      eng_byte = m_tx_byte;
      eng_cnt  = int'($urandom_range(eng_hi, eng_lo));
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        m_tx_ready = 1'b1;
        m_rx_dv    = 1'b1;
        m_rx_byte  = eng_byte;
      end else begin
        m_tx_ready = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    engine();
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(tag, tx_ready, 1);
  endtask

  // Walk the engine's busy period; upstream must see not-ready, and stray DVs must be dropped.
  task automatic busy_gap();
    int n = 0;
    while (eng_cnt > 0 && n < 40) begin
      chk("busy_ready_low", tx_ready, 0);
      if ($urandom_range(1, 0) == 1) begin
        tx_dv    = 1'b1;
        tx_byte  = 8'($urandom);
        tx_count = CW'(1);
      end
      step();
      tx_dv = 1'b0;
      n++;
    end
  endtask

  task automatic send_window(input int cnt, input logic [7:0] b0, input logic [7:0] b1);
    bit legal;
    int n;
    legal = (cnt >= 1) && (cnt <= MaxBytes);
    wait_ready("idle_ready");
    tx_count = CW'(cnt);
    tx_byte  = b0;
    tx_dv    = 1'b1;
    if (legal) begin
      exp_fwd.push_back(b0);
      exp_rx_byte.push_back(b0);
      exp_rx_idx.push_back(0);
      if (cnt == 2) begin
        exp_fwd.push_back(b1);
        exp_rx_byte.push_back(b1);
        exp_rx_idx.push_back(1);
      end
      exp_windows++;
      first_pending = 1'b1;
      acc_cyc       = cyc;
      saw_fwd       = 1'b0;
    end
    step();
    tx_dv = 1'b0;
    if (!legal) begin
      repeat (4) begin
        chk("drop_cs_high", cs_n, 1);
        chk("drop_ready_high", tx_ready, 1);
        step();
      end
      return;
    end
    n = 0;
    while (!saw_fwd && n < LeadExp + 4) begin
      chk("lead_cs_low", cs_n, 0);
      step();
      n++;
    end
    chk("first_fwd_seen", saw_fwd, 1);
    busy_gap();
    if (cnt == 2) begin
      repeat ($urandom_range(2, 0)) step();
      wait_ready("next_ready");
      chk("mid_cs_low", cs_n, 0);
      tx_byte  = b1;
      tx_count = CW'($urandom_range(3, 0));
      tx_dv    = 1'b1;
      step();
      tx_dv = 1'b0;
      busy_gap();
    end
    n = 0;
    while (cs_n !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("cs_release", cs_n, 1);
    for (int i = 0; i < InactClks; i++) begin
      chk("inactive_ready_low", tx_ready, 0);
      step();
    end
    chk("idle_ready_back", tx_ready, 1);
    chk("rx_all_seen", exp_rx_idx.size(), 0);
    chk("one_cs_window", cs_falls, exp_windows);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst        = 1'b1;
    tx_count   = '0;
    tx_byte    = '0;
    tx_dv      = 1'b0;
    m_tx_ready = 1'b1;
    m_rx_dv    = 1'b0;
    m_rx_byte  = '0;
    repeat (2) step();
    chk("rst_cs_n", cs_n, 1);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_m_tx_dv", m_tx_dv, 0);
    chk("rst_rx_dv", rx_dv, 0);
    chk("rst_m_tx_byte", m_tx_byte, 0);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_rx_count", rx_count, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", tx_ready, 1);
    chk("idle_cs_high", cs_n, 1);

    send_window(1, 8'hA5, 8'h00);
    send_window(2, 8'h12, 8'h34);
    send_window(0, 8'h77, 8'h00);
    send_window(3, 8'h88, 8'h00);

    repeat (24) begin
      send_window(int'($urandom_range(3, 0)), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(3, 0)) step();
    end

    // Abort a two-byte window while the first byte is still shifting.
    eng_lo = 16;
    eng_hi = 16;
    wait_ready("rst_idle_ready");
    tx_count = CW'(2);
    tx_byte  = 8'h5A;
    tx_dv    = 1'b1;
    exp_fwd.push_back(8'h5A);
    exp_windows++;
    first_pending = 1'b1;
    acc_cyc       = cyc;
    saw_fwd       = 1'b0;
    step();
    tx_dv = 1'b0;
    n = 0;
    while (!saw_fwd && n < LeadExp + 4) begin
      step();
      n++;
    end
    chk("rst_fwd_seen", saw_fwd, 1);
    repeat (5) step();
    chk("rst_pre_cs_low", cs_n, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cs_n", cs_n, 1);
    chk("rst_async_ready", tx_ready, 0);
    chk("rst_async_m_tx_dv", m_tx_dv, 0);
    chk("rst_async_rx_byte", rx_byte, 0);
    chk("rst_async_m_tx_byte", m_tx_byte, 0);
    eng_cnt    = 0;
    m_tx_ready = 1'b1;
    m_rx_dv    = 1'b0;
    repeat (2) step();
    rst    = 1'b0;
    eng_lo = 3;
    eng_hi = 8;
    repeat (20) begin
      step();
      chk("post_rst_cs_high", cs_n, 1);
    end
    chk("post_rst_ready", tx_ready, 1);
    chk("post_rst_windows", cs_falls, exp_windows);

    send_window(2, 8'($urandom), 8'($urandom));
    repeat (4) step();
    chk("final_fwd_drained", exp_fwd.size(), 0);
    chk("final_rx_drained", exp_rx_idx.size(), 0);
    chk("final_windows", cs_falls, exp_windows);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
